// File: rtl/pulse_period_monitor.sv
// Receive-side checker for the periodic tick strobe: measures strobe intervals,
// flags early/late strobes and declares lock after a run of good intervals.
module pulse_period_monitor #(
  parameter int PERIOD   = 2501,
  parameter int TOL      = 0,
  parameter int LOCK_CNT = 2,
  parameter int CBITS    = 12
)(
  input  logic             clk,
  input  logic             rst,
  input  logic             pulse_in,
  output logic             locked,
  output logic             early,
  output logic             late,
  output logic             err_sticky,
  output logic [CBITS-1:0] last_period
);

  localparam int KBITS = $clog2(LOCK_CNT + 1);
  localparam logic [CBITS-1:0] LO     = CBITS'(PERIOD - TOL);
  localparam logic [CBITS-1:0] LATE_T = CBITS'(PERIOD + TOL + 1);
  localparam logic [KBITS-1:0] KMAX   = KBITS'(LOCK_CNT);

  typedef enum logic [1:0] {IDLE, TRACK, LOCK} state_t;

  state_t           state_q, state_d;
  logic [CBITS-1:0] t_q, t_d;
  logic [KBITS-1:0] consec_q, consec_d, consec_inc;
  logic [CBITS-1:0] lp_d;
  logic             early_d, late_d, err_d;

  assign consec_inc = (consec_q >= KMAX) ? KMAX : consec_q + KBITS'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      t_q         <= '0;
      consec_q    <= '0;
      early       <= 1'b0;
      late        <= 1'b0;
      err_sticky  <= 1'b0;
      last_period <= '0;
    end else begin
      state_q     <= state_d;
      t_q         <= t_d;
      consec_q    <= consec_d;
      early       <= early_d;
      late        <= late_d;
      err_sticky  <= err_d;
      last_period <= lp_d;
    end
  end

  // locked is a straight decode of the state flop, so it shares its timing
  assign locked = (state_q == LOCK);

  always_comb begin
    state_d  = state_q;
    t_d      = t_q;
    consec_d = consec_q;
    lp_d     = last_period;
    early_d  = 1'b0;
    late_d   = 1'b0;
    err_d    = err_sticky;
    if (state_q == IDLE) begin
      t_d = '0;
      if (pulse_in) begin
        state_d  = TRACK;
        t_d      = CBITS'(1);
        consec_d = '0;
      end
    end else if (t_q == LATE_T) begin
      // timeout wins over any strobe in the same cycle; a strobe here resyncs
      late_d   = 1'b1;
      err_d    = 1'b1;
      consec_d = '0;
      if (pulse_in) begin
        state_d = TRACK;
        t_d     = CBITS'(1);
        lp_d    = t_q;
      end else begin
        state_d = IDLE;
        t_d     = '0;
      end
    end else if (pulse_in && (t_q < LO)) begin
      early_d  = 1'b1;
      err_d    = 1'b1;
      consec_d = '0;
      state_d  = TRACK;
      t_d      = CBITS'(1);
      lp_d     = t_q;
    end else if (pulse_in) begin
      lp_d     = t_q;
      t_d      = CBITS'(1);
      consec_d = consec_inc;
      state_d  = (consec_inc == KMAX) ? LOCK : TRACK;
    end else begin
      t_d = t_q + CBITS'(1);
    end
  end

endmodule

// File: tb/tb_pulse_period_monitor.sv
// Directed bench: a driver plays strobe schedules and queues expectations,
// a monitor pops and compares snapshots and early/late events independently.
module tb_pulse_period_monitor;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic pa = 1'b0, pb = 1'b0;
  logic lk_a, ea_a, la_a, er_a, lk_b, ea_b, la_b, er_b;
  logic [11:0] lp_a, lp_b;

  always #5 clk = ~clk;

  pulse_period_monitor #(.PERIOD(2501), .TOL(0), .LOCK_CNT(2), .CBITS(12)) ua (
    .clk(clk), .rst(rst), .pulse_in(pa), .locked(lk_a), .early(ea_a),
    .late(la_a), .err_sticky(er_a), .last_period(lp_a));

  pulse_period_monitor #(.PERIOD(2501), .TOL(2), .LOCK_CNT(2), .CBITS(12)) ub (
    .clk(clk), .rst(rst), .pulse_in(pb), .locked(lk_b), .early(ea_b),
    .late(la_b), .err_sticky(er_b), .last_period(lp_b));

  typedef struct {int seg; int cyc; int dut; bit lk; bit ea; bit la; bit er; int lp;} snap_t;
  typedef struct {int seg; int cyc; int dut; bit is_late;} ev_t;

  snap_t sb[$];
  ev_t   evq[$];
  int    sq[$];
  int    seg = 0, cyc = 0, dsel = 0, rst_at = -1;
  bit    active = 1'b0;
  int    n_vec = 0, n_err = 0;

  task automatic exp_s(input int c, input bit l, input bit e, input bit la, input bit er, input int lp);
    snap_t s;
    s.seg = seg; s.cyc = c; s.dut = dsel; s.lk = l; s.ea = e; s.la = la; s.er = er; s.lp = lp;
    sb.push_back(s);
  endtask

  task automatic exp_e(input int c, input bit is_late);
    ev_t v;
    v.seg = seg; v.cyc = c; v.dut = dsel; v.is_late = is_late;
    evq.push_back(v);
  endtask

  task automatic drive();
    bit p;
    p = 1'b0;
    if (sq.size() > 0 && sq[0] == cyc) begin
      p = 1'b1;
      void'(sq.pop_front());
    end
    rst = (cyc == rst_at);
    pa  = (dsel == 0) ? p : 1'b0;
    pb  = (dsel == 1) ? p : 1'b0;
  endtask

  task automatic run_seg(input int len);
    snap_t s;
    ev_t   v;
    rst = 1'b1; pa = 1'b0; pb = 1'b0; active = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    cyc = 0; active = 1'b1;
    drive();
    for (int i = 1; i < len; i++) begin
      @(posedge clk); #1;
      cyc = i;
      drive();
    end
    @(posedge clk); #1;
    active = 1'b0;
    while (sb.size() > 0 && sb[0].seg == seg) begin
      s = sb.pop_front();
      n_vec++; n_err++;
      $display("FAIL snap_unchecked seg%0d cyc%0d: never sampled", s.seg, s.cyc);
    end
    while (evq.size() > 0 && evq[0].seg == seg) begin
      v = evq.pop_front();
      n_vec++; n_err++;
      $display("FAIL event_missing seg%0d cyc%0d late=%0d: no pulse seen", v.seg, v.cyc, v.is_late);
    end
    sq.delete();
    rst_at = -1;
    seg++;
  endtask

  // snapshot and event checking
  always @(negedge clk) begin : mon
    snap_t s;
    ev_t   v;
    bit    a_lk, a_ea, a_la, a_er;
    int    a_lp;
    if (active) begin
      while (sb.size() > 0 && sb[0].seg == seg && sb[0].cyc == cyc) begin
        s = sb.pop_front();
        a_lk = (s.dut == 0) ? lk_a : lk_b;
        a_ea = (s.dut == 0) ? ea_a : ea_b;
        a_la = (s.dut == 0) ? la_a : la_b;
        a_er = (s.dut == 0) ? er_a : er_b;
        a_lp = (s.dut == 0) ? int'(lp_a) : int'(lp_b);
        n_vec++;
        if (a_lk !== s.lk || a_ea !== s.ea || a_la !== s.la || a_er !== s.er || a_lp != s.lp) begin
          n_err++;
          $display("FAIL snap seg%0d cyc%0d dut%0d: got lk=%0b e=%0b l=%0b err=%0b lp=%0d want lk=%0b e=%0b l=%0b err=%0b lp=%0d",
                   s.seg, s.cyc, s.dut, a_lk, a_ea, a_la, a_er, a_lp, s.lk, s.ea, s.la, s.er, s.lp);
        end
      end
      for (int d = 0; d < 2; d++) begin
        a_ea = (d == 0) ? ea_a : ea_b;
        a_la = (d == 0) ? la_a : la_b;
        if (a_ea || a_la) begin
          n_vec++;
          if (evq.size() == 0) begin
            n_err++;
            $display("FAIL event seg%0d cyc%0d dut%0d: got e=%0b l=%0b want none", seg, cyc, d, a_ea, a_la);
          end else begin
            v = evq[0];
            if (v.seg != seg || v.cyc != cyc || v.dut != d || a_ea == a_la || a_la != v.is_late) begin
              n_err++;
              $display("FAIL event seg%0d cyc%0d dut%0d: got e=%0b l=%0b want cyc%0d dut%0d late=%0b",
                       seg, cyc, d, a_ea, a_la, v.cyc, v.dut, v.is_late);
            end
            if (v.seg == seg && v.cyc == cyc && v.dut == d) void'(evq.pop_front());
          end
        end
      end
    end
  end

  initial begin
    // seg 0: lock acquisition, then an early strobe out of lock
    dsel = 0;
    sq = '{10, 2511, 5012, 7512};
    exp_s(0, 0, 0, 0, 0, 0);
    exp_s(11, 0, 0, 0, 0, 0);
    exp_s(2511, 0, 0, 0, 0, 0);
    exp_s(2512, 0, 0, 0, 0, 2501);
    exp_s(5012, 0, 0, 0, 0, 2501);
    exp_s(5013, 1, 0, 0, 0, 2501);
    exp_s(7512, 1, 0, 0, 0, 2501);
    exp_s(7513, 0, 1, 0, 1, 2500);
    exp_s(7514, 0, 0, 0, 1, 2500);
    exp_e(7513, 0);
    run_seg(7520);

    // seg 1: timeout out of lock, reacquire from IDLE
    dsel = 0;
    sq = '{10, 2511, 5012, 8000, 10501, 13002};
    exp_s(0, 0, 0, 0, 0, 0);
    exp_s(7514, 1, 0, 0, 0, 2501);
    exp_s(7515, 0, 0, 1, 1, 2501);
    exp_s(7516, 0, 0, 0, 1, 2501);
    exp_s(8001, 0, 0, 0, 1, 2501);
    exp_s(10502, 0, 0, 0, 1, 2501);
    exp_s(13002, 0, 0, 0, 1, 2501);
    exp_s(13003, 1, 0, 0, 1, 2501);
    exp_e(7515, 1);
    run_seg(13010);

    // seg 2: strobe held high for three cycles
    dsel = 0;
    sq = '{10, 2511, 2512, 2513};
    exp_s(0, 0, 0, 0, 0, 0);
    exp_s(2512, 0, 0, 0, 0, 2501);
    exp_s(2513, 0, 1, 0, 1, 1);
    exp_s(2514, 0, 1, 0, 1, 1);
    exp_s(2515, 0, 0, 0, 1, 1);
    exp_e(2513, 0);
    exp_e(2514, 0);
    run_seg(2520);

    // seg 3: reset with strobe while locked and sticky error set
    dsel = 0;
    sq = '{10, 2511, 3000, 5501, 8002, 8010, 8020, 10521};
    rst_at = 8010;
    exp_s(0, 0, 0, 0, 0, 0);
    exp_s(3001, 0, 1, 0, 1, 489);
    exp_s(5502, 0, 0, 0, 1, 2501);
    exp_s(8003, 1, 0, 0, 1, 2501);
    exp_s(8010, 1, 0, 0, 1, 2501);
    exp_s(8011, 0, 0, 0, 0, 0);
    exp_s(8021, 0, 0, 0, 0, 0);
    exp_s(10522, 0, 0, 0, 0, 2501);
    exp_e(3001, 0);
    run_seg(10530);

    // seg 4: TOL=2 window edges, timeout, and strobe exactly at timeout
    dsel = 1;
    sq = '{10, 2509, 5012, 8000, 10504, 13005};
    exp_s(0, 0, 0, 0, 0, 0);
    exp_s(2510, 0, 0, 0, 0, 2499);
    exp_s(5013, 1, 0, 0, 0, 2503);
    exp_s(7516, 1, 0, 0, 0, 2503);
    exp_s(7517, 0, 0, 1, 1, 2503);
    exp_s(10504, 0, 0, 0, 1, 2503);
    exp_s(10505, 0, 0, 1, 1, 2504);
    exp_s(13006, 0, 0, 0, 1, 2501);
    exp_e(7517, 1);
    exp_e(10505, 1);
    run_seg(13010);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
